// File: rtl/sum_accumulator.sv
// Sums COUNT unsigned samples into an ACC_W total and holds it with a sticky overflow flag until downstream takes it.
// Result visible the cycle after the COUNT-th accept; in_ready drops while a result waits; SUM_ACC_SATURATE_EN clamps instead of wrapping.
module sum_accumulator #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 10,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       sample_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] COUNT_B = 8'(COUNT);

  state_t           state;
  logic             accept;
  logic             ret;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] next_acc;
  logic [7:0]       next_cnt;

  assign in_ready = (state != DONE);
  assign accept   = in_valid && in_ready;
  assign ret      = out_valid && out_ready;
  assign sum_ext  = {1'b0, acc_out} + (ACC_W+1)'(sum_in);
  assign next_cnt = sample_cnt + 8'd1;

`ifdef SUM_ACC_SATURATE_EN
  // Once clamped, any further non-zero add carries again, so the total stays pinned.
  assign next_acc = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign next_acc = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc_out    <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      sample_cnt <= 8'd0;
    end else if (clear) begin
      state      <= IDLE;
      acc_out    <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      sample_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_out    <= ACC_W'(sum_in);
            overflow   <= 1'b0;
            sample_cnt <= 8'd1;
            if (COUNT_B == 8'd1) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_out    <= next_acc;
            overflow   <= overflow | sum_ext[ACC_W];
            sample_cnt <= next_cnt;
            if (next_cnt == COUNT_B) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ret) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            sample_cnt <= 8'd0;
            acc_out    <= '0;
            overflow   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
